// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver (8N1; 8E1 when UART_RX_PARITY_EN is defined)
// feeding a first-word-fall-through byte FIFO with framing, parity and overrun flags.
module uart_rx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               uart_rx,
  input  logic [15:0]        divisor,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int PW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  state_t          state, state_next;
  logic            sync1, rxs;
  logic [15:0]     tick_cnt, reload;
  logic            tick, t9, t15;
  logic [3:0]      phase;
  logic [2:0]      bit_idx;
  logic            samp7, samp8, maj;
  logic [7:0]      shreg;
  logic            par_bad;
  logic            leave_idle, shift_en, par_cap, push_req, frame_bad, par_fail;
  logic [FIFO_AW:0] wptr, rptr, wr_next, rd_next, level_next;
  logic            pop, push_ok, overflow;
  logic [7:0]      head_next;
  logic [7:0]      mem [DEPTH];

  assign reload = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  assign tick   = (tick_cnt == 16'd0);
  assign t9     = tick && (phase == 4'd9);
  assign t15    = tick && (phase == 4'd15);
  assign maj    = maj3(samp7, samp8, rxs);

  // two-flop synchronizer, idle-high after reset
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // oversample tick; re-phased on the start edge
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tick_cnt <= 16'd0;
    end else if (leave_idle || tick) begin
      tick_cnt <= reload;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  // next-state and per-tick strobes
  always_comb begin
    state_next = state;
    leave_idle = 1'b0;
    shift_en   = 1'b0;
    par_cap    = 1'b0;
    push_req   = 1'b0;
    frame_bad  = 1'b0;
    par_fail   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          leave_idle = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (t9 && maj) begin
          state_next = IDLE;
        end else if (t15) begin
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        shift_en = t9;
        if (t15 && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_cap = t9;
        if (t15) begin
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
`endif
      STOP: begin
        // leave at mid-stop so a slightly fast sender is still caught
        if (t9) begin
          if (!maj) begin
            frame_bad  = 1'b1;
            state_next = BRK;
          end else if (par_bad) begin
            par_fail   = 1'b1;
            state_next = IDLE;
          end else begin
            push_req   = 1'b1;
            state_next = IDLE;
          end
        end else begin
          state_next = STOP;
        end
      end
      BRK: begin
        if (rxs) begin
          state_next = IDLE;
        end else begin
          state_next = BRK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // bit timing, majority samples and data shift register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      phase   <= 4'd0;
      bit_idx <= 3'd0;
      samp7   <= 1'b1;
      samp8   <= 1'b1;
      shreg   <= 8'd0;
    end else begin
      if (state == IDLE) begin
        phase <= 4'd0;
      end else if (tick) begin
        phase <= phase + 4'd1;
      end
      if (state != DATA) begin
        bit_idx <= 3'd0;
      end else if (t15) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (tick && (phase == 4'd7)) samp7 <= rxs;
      if (tick && (phase == 4'd8)) samp8 <= rxs;
      if (shift_en) shreg <= {maj, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // even-parity mismatch latched at the parity bit
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      par_bad <= 1'b0;
    end else if (par_cap) begin
      par_bad <= (maj != even_par(shreg));
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  assign pop        = rx_valid && rx_ready;
  assign overflow   = push_req && (fifo_level == PW'(DEPTH)) && !pop;
  assign push_ok    = push_req && !overflow;
  assign wr_next    = wptr + PW'(push_ok);
  assign rd_next    = rptr + PW'(pop);
  assign level_next = wr_next - rd_next;
  assign fifo_level = wptr - rptr;

  // head after this edge: the incoming byte when it lands in the head slot
  always_comb begin
    if (push_ok && (wptr[FIFO_AW-1:0] == rd_next[FIFO_AW-1:0])) begin
      head_next = shreg;
    end else begin
      head_next = mem[rd_next[FIFO_AW-1:0]];
    end
  end

  // FIFO storage
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= shreg;
  end

  // FIFO pointers, registered head and error pulses
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wptr       <= {PW{1'b0}};
      rptr       <= {PW{1'b0}};
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wptr       <= wr_next;
      rptr       <= rd_next;
      rx_valid   <= (level_next != {PW{1'b0}});
      if (level_next != {PW{1'b0}}) rx_data <= head_next;
      frame_err  <= frame_bad;
      parity_err <= par_fail;
      overrun    <= overflow;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (FIFO_AW=2): directed frames, FIFO limits,
// reset mid-frame and randomized frames against a byte-level expectation queue.
module tb_uart_rx_fifo;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 173;
`else
  localparam int LAT = 157;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst, uart_rx, rx_ready;
  logic [15:0] divisor;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, parity_err, overrun;
  logic [AW:0] fifo_level;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, frame_start = 0, rise_cyc = -1;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, long_cnt = 0;
  logic fe_q = 1'b0, pe_q = 1'b0, ov_q = 1'b0, valid_q = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  int bt = 16;
`ifdef UART_RX_PARITY_EN
  bit par_flip_g = 1'b0;
`endif

  uart_rx_fifo #(.FIFO_AW(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx), .divisor(divisor),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .fifo_level(fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // pulse counters, pulse-width watch, rx_valid rise time, popped bytes
  always @(negedge sys_clk) begin
    fe_q    <= frame_err;
    pe_q    <= parity_err;
    ov_q    <= overrun;
    valid_q <= rx_valid;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (overrun)    ov_cnt <= ov_cnt + 1;
    if ((frame_err && fe_q) || (parity_err && pe_q) || (overrun && ov_q)) long_cnt <= long_cnt + 1;
    if (rx_valid && !valid_q) rise_cyc <= cyc;
    if (rx_valid && rx_ready) got.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_got(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic set_div(input int d);
    divisor = 16'(d);
    bt = 16 * ((d <= 1) ? 1 : d);
  endtask

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    @(posedge sys_clk);
    #1;
    frame_start = cyc;
    drive(1'b0, bt);
    for (int i = 0; i < 8; i++) drive(b[i], bt);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ par_flip_g, bt);
`endif
    if (stop_low > 0) drive(1'b0, stop_low);
    drive(1'b1, bt);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int fe0, ov0, pe0, exp_fe, exp_pe, kind, gap;
    logic [7:0] b;
    exp_pe = 0;
    sys_rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
    set_div(1);
    cycles(3);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_flags", {frame_err, parity_err, overrun}, 3'b000);
    sys_rst = 1'b0;
    cycles(20);

    // single byte, latency, then one pop
    send_frame(8'h41, 0);
    cycles(4);
    check("lat_41", 32'(rise_cyc - frame_start), LAT);
    check("data_41", rx_data, 8'h41);
    check("valid_41", rx_valid, 1'b1);
    check("level_41", fifo_level, 3'd1);
    rx_ready = 1'b1;
    cycles(1);
    check("valid_after_pop", rx_valid, 1'b0);
    check("hold_after_pop", rx_data, 8'h41);
    exp_q.push_back(8'h41);
    compare_got("pop_41");

    // short glitch: no frame, no flag
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    cycles(6);
    uart_rx = 1'b1;
    cycles(40);
    check("glitch_level", fifo_level, 3'd0);
    check("glitch_fe", fe_cnt, fe0);
    send_frame(8'h5A, 0);
    cycles(4);
    exp_q.push_back(8'h5A);
    compare_got("after_glitch");

    // bad stop held low, then a good frame
    send_frame(8'h55, 32);
    cycles(16);
    check("brk_fe", fe_cnt, fe0 + 1);
    send_frame(8'hA5, 0);
    cycles(4);
    check("brk_fe_once", fe_cnt, fe0 + 1);
    exp_q.push_back(8'hA5);
    compare_got("after_break");

    // overrun on the fifth byte
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0);
      if (mq.size() < DEPTH) mq.push_back(8'(i));
      if (i == 4) check("ov_not_yet", ov_cnt, ov0);
    end
    cycles(2);
    check("ov_pulse", ov_cnt, ov0 + 1);
    check("ov_level", fifo_level, 3'd4);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("drain_valid", rx_valid, 1'b1);
      check("drain_data", rx_data, mq[i]);
      cycles(1);
    end
    rx_ready = 1'b0;
    check("drain_empty", rx_valid, 1'b0);
    check("drain_hold", rx_data, mq[3]);
    exp_q = mq;
    mq.delete();
    compare_got("drain");

    // full with push and pop on the same edge
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h11 + 8'(i), 0);
      mq.push_back(8'h11 + 8'(i));
    end
    ov0 = ov_cnt;
    fork
      send_frame(8'h15, 0);
      begin
        @(posedge sys_clk);
        #1;
        repeat (LAT - 1) @(posedge sys_clk);
        #1;
        rx_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    exp_q.push_back(mq.pop_front());
    mq.push_back(8'h15);
    cycles(2);
    check("fullpop_ov", ov_cnt, ov0);
    check("fullpop_level", fifo_level, 3'd4);
    rx_ready = 1'b1;
    cycles(8);
    foreach (mq[i]) exp_q.push_back(mq[i]);
    mq.delete();
    compare_got("fullpop");

`ifdef UART_RX_PARITY_EN
    // wrong parity discarded, right parity accepted
    rx_ready = 1'b0;
    pe0 = pe_cnt;
    par_flip_g = 1'b1;
    send_frame(8'h07, 0);
    cycles(2);
    exp_pe = exp_pe + 1;
    check("par_bad_pulse", pe_cnt, pe0 + 1);
    check("par_bad_level", fifo_level, 3'd0);
    par_flip_g = 1'b0;
    send_frame(8'h07, 0);
    cycles(2);
    check("par_ok_level", fifo_level, 3'd1);
    check("par_ok_data", rx_data, 8'h07);
    rx_ready = 1'b1;
    cycles(2);
    exp_q.push_back(8'h07);
    compare_got("parity");
`endif

    // reset in the middle of a data byte
    rx_ready = 1'b0;
    send_frame(8'h3C, 0);
    cycles(2);
    check("pre_rst_level", fifo_level, 3'd1);
    drive(1'b0, bt);
    drive(1'b1, bt);
    drive(1'b0, 5);
    sys_rst = 1'b1;
    #1;
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_data", rx_data, 8'h00);
    uart_rx = 1'b1;
    cycles(3);
    sys_rst = 1'b0;
    cycles(40);
    check("post_rst_level", fifo_level, 3'd0);
    rx_ready = 1'b1;
    send_frame(8'h96, 0);
    cycles(4);
    exp_q.push_back(8'h96);
    compare_got("post_rst");

    // randomized frames, bad stops and glitches at assorted divisors
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_fe = 0;
    for (int n = 0; n < 24; n++) begin
      set_div(int'($urandom_range(0, 3)));
      cycles(4);
      kind = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (kind == 0) begin
        uart_rx = 1'b0;
        cycles(int'($urandom_range(1, 6)));
        uart_rx = 1'b1;
        cycles(2 * bt);
      end else if (kind == 1) begin
        send_frame(b, 2 * bt);
        exp_fe = exp_fe + 1;
      end else begin
        send_frame(b, 0);
        exp_q.push_back(b);
      end
      gap = int'($urandom_range(0, 20));
      cycles(gap);
    end
    cycles(20);
    compare_got("random");
    check("random_fe", fe_cnt, fe0 + exp_fe);
    check("random_ov", ov_cnt, ov0);
    check("parity_pulses", pe_cnt, exp_pe);
    check("pulse_width", long_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling UART receiver with a first-word-fall-through byte FIFO. It is the receive-side counterpart of the team's periodic UART transmitter, and runs from the same `sys_clk` and the same 16x `divisor` convention. It recovers 8N1 frames (8E1 with parity enabled) from the asynchronous `uart_rx` pin and presents bytes on a valid/ready stream. It flags framing, parity and overrun errors.

## Interface
- `FIFO_AW`, default 4: FIFO address width; depth = 2^`FIFO_AW` bytes.
- `sys_clk`  in  1: system clock; all logic on its rising edge.
- `sys_rst`  in  1: asynchronous, active-high reset.
- `uart_rx`  in  1: serial input; asynchronous, idle high.
- `divisor`  in  16: `sys_clk` cycles per oversample tick, i.e. clk_freq/baud/16. Values 0 and 1 both mean a tick every cycle.
- `rx_data`  out  8: FIFO head byte; meaningful only while `rx_valid` is high.
- `rx_valid`  out  1: FIFO not empty.
- `rx_ready`  in  1: consumer accepts the head byte.
- `frame_err`  out  1: one-cycle pulse when a bad stop bit is detected.
- `parity_err`  out  1: one-cycle pulse on parity mismatch; tied 0 without parity.
- `overrun`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_level`  out  `FIFO_AW`+1: current occupancy, 0..2^`FIFO_AW`.

## Operation
- **Input synchronizer:** 2-flop chain on `uart_rx`; both flops reset to 1. All frame logic uses the synchronized bit `rxs`.
- **Tick generator:** down-counter reloads with `divisor`-1 and pulses `tick` at 0. It is forced to reload whenever the FSM leaves IDLE, so the bit phase is aligned to the detected start edge.
- **Bit timing:** a 4-bit `phase` counts ticks within a bit (0..15). Sample `rxs` at phases 7, 8 and 9. The bit value is the 2-of-3 majority, decided at phase 9.
- **FSM states:**
  - IDLE: on `rxs`=0, go to START with phase=0.
  - START: majority at phase 9. If 1 (glitch), return to IDLE; no flags. If 0, continue to DATA at phase 15→0.
  - DATA: 8 bits shifted in LSB first; after bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY: capture the bit and compare it to the even parity of the data byte.
  - STOP, majority 1 at phase 9: push the byte (unless parity failed, in which case pulse `parity_err` and discard), then go directly to IDLE at phase 9. Returning at mid-stop tolerates a sender up to ~3% fast.
  - STOP, majority 0 at phase 9: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A line held low produces no further frames or flags.
- **FIFO:** dual-pointer with an extra wrap bit. Push on a good stop; pop on `rx_valid` && `rx_ready`.
  - Full, push only: byte dropped, `overrun` pulses, contents unchanged.
  - Full, simultaneous push and pop: both occur, no overrun, level unchanged.
  - Empty: `rx_ready` is ignored; `rx_data` holds the last value.
  - Pointers wrap modulo 2^`FIFO_AW`.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `fifo_level`=0. FSM=IDLE, pointers=0, synchronizer=1.
- **Reset mid-frame:** the partial byte is lost and the FIFO is emptied. After release, a new start requires a fresh falling edge on `rxs`.
- **Pin-to-FSM latency:** 2 cycles through the synchronizer.
- **Push latency:** the byte is written on the cycle of the phase-9 tick of the stop bit. `rx_valid` and `rx_data` update on the next cycle.
- **Pop:** takes effect at the clock edge where `rx_valid` && `rx_ready`. The next head byte (or `rx_valid`=0) appears in the following cycle. Back-to-back pops are sustained at one per cycle.
- **Error pulses:** exactly one `sys_clk` cycle each, coincident with the push/discard decision cycle.
- **Divisor changes:** take effect at the next reload; software changes `divisor` only while the line is idle.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the frame is start + 8 data + even parity + stop. The PARITY state exists. A mismatch discards the byte and pulses `parity_err`; the stop bit is still checked, and `frame_err` takes precedence if both fail.
- **`UART_RX_PARITY_EN` undefined:** 8N1 only. The PARITY state and checker are absent, and `parity_err` is constant 0.

## Test plan
- `divisor`=1, 8N1 byte 0x41 sent at 16 cycles/bit → `rx_valid` rises and `rx_data`=0x41 one cycle after the stop-bit phase-9 tick; `fifo_level`=1. Assert `rx_ready` → `rx_valid`=0 next cycle.
- 6-cycle low glitch on `uart_rx` while idle → FSM returns to IDLE from START; no push, no flags.
- Frame 0x55 with stop bit held 0 for 32 cycles → one `frame_err` pulse, no push; FSM stays in BREAK until the line goes high, and the next frame 0xA5 is received correctly.
- `FIFO_AW`=2: send 5 bytes 0x01..0x05 with `rx_ready`=0 → `fifo_level`=4 and one `overrun` pulse on byte 0x05. Then pop with `rx_ready`=1 for 4 cycles → reads 0x01..0x04 back-to-back, `rx_valid`=0 after.
- FIFO full, stop decision coinciding with a pop → no `overrun`, `fifo_level` stays 4, new byte appears last in order.
- With `UART_RX_PARITY_EN`: 0x07 sent with parity bit 0 (wrong) → one `parity_err` pulse, no push. With parity bit 1 → pushed. Also: assert `sys_rst` mid-DATA of a byte → all outputs are at reset values immediately, and the next full frame is received cleanly.
